// File: rtl/instr_mix_profiler.sv
// Passive instruction-mix profiler: classifies each instruction once on decode entry
// and keeps saturating per-class counters plus the PC of the first illegal encoding.
module instr_mix_profiler #(
  parameter int          CNT_W        = 32,
  parameter logic [2:0]  DECODE_STATE = 3'b001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       state,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             illegal_seen
);

  localparam logic [2:0] C_BR    = 3'd0;
  localparam logic [2:0] C_LD    = 3'd1;
  localparam logic [2:0] C_ST    = 3'd2;
  localparam logic [2:0] C_IMM   = 3'd3;
  localparam logic [2:0] C_REG   = 3'd4;
  localparam logic [2:0] C_ILL   = 3'd5;
  localparam int         N_CNT   = 7;

  logic [CNT_W-1:0] r_cnt [N_CNT];
  logic [31:0]      r_illegal_pc;
  logic             r_illegal_seen;
  logic             r_in_dec;
  logic [CNT_W-1:0] r_rd_data;

  logic [6:0]       w_op;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [2:0]       w_cls;
  logic             w_in_dec;
  logic             w_event;
  logic [6:0]       w_hit;
  logic [CNT_W-1:0] w_pc_rd;
  logic [CNT_W-1:0] w_mux;

  assign w_op     = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_in_dec = (state == DECODE_STATE);
  assign w_event  = w_in_dec & ~r_in_dec & en;

  always_comb begin
    w_cls = C_ILL;
    case (w_op)
      7'b1100011: if (w_f3 == 3'b000) w_cls = C_BR;
      7'b0000011: if (w_f3 == 3'b010) w_cls = C_LD;
      7'b0100011: if (w_f3 == 3'b010) w_cls = C_ST;
      7'b0010011: begin
        case (w_f3)
          3'b001:  if (w_f7 == 7'b0000000) w_cls = C_IMM;
          3'b101:  if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) w_cls = C_IMM;
          default: w_cls = C_IMM;
        endcase
      end
      7'b0110011: begin
        if (w_f3 == 3'b000 || w_f3 == 3'b101) begin
          if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) w_cls = C_REG;
        end else if (w_f7 == 7'b0000000) begin
          w_cls = C_REG;
        end
      end
      default: w_cls = C_ILL;
    endcase
  end

  // Bit 6 is TOTAL; it moves with whichever class counter fires.
  always_comb begin
    w_hit = 7'd0;
    if (w_event) w_hit = 7'b1000000 | (7'd1 << w_cls);
  end

  generate
    if (CNT_W > 32) begin : g_pc_wide
      assign w_pc_rd = {{(CNT_W-32){1'b0}}, r_illegal_pc};
    end else if (CNT_W == 32) begin : g_pc_eq
      assign w_pc_rd = r_illegal_pc;
    end else begin : g_pc_narrow
      assign w_pc_rd = r_illegal_pc[CNT_W-1:0];
    end
  endgenerate

  always_comb begin
    w_mux = '0;
    case (sel)
      3'd7:    w_mux = w_pc_rd;
      default: w_mux = r_cnt[sel];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_dec  <= 1'b1;
      r_rd_data <= '0;
    end else begin
      r_in_dec  <= w_in_dec;
      r_rd_data <= w_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
      r_illegal_pc   <= '0;
      r_illegal_seen <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
      r_illegal_pc   <= '0;
      r_illegal_seen <= 1'b0;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        if (w_hit[i] && (r_cnt[i] != {CNT_W{1'b1}})) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
      // Only the first illegal encoding since reset/clear records its PC.
      if (w_event && (w_cls == C_ILL) && !r_illegal_seen) begin
        r_illegal_pc   <= pc;
        r_illegal_seen <= 1'b1;
      end
    end
  end

  assign rd_data      = r_rd_data;
  assign illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_instr_mix_profiler.sv
// Bench for instr_mix_profiler: a 32-bit and a 4-bit instance share stimulus and are
// checked every cycle against a spec-level model, plus literal readouts per scenario.
module tb_instr_mix_profiler;

  localparam logic [2:0] DEC  = 3'b001;
  localparam logic [2:0] IDLE = 3'b010;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] LW   = 32'h0000_2103;
  localparam logic [31:0] SW   = 32'h0020_2223;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] SUB  = 32'h4020_81B3;
  localparam logic [31:0] BAD0 = 32'h0000_007F;
  localparam logic [31:0] BAD1 = 32'hFE00_5013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic [2:0]  state = IDLE;
  logic [31:0] instr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic [2:0]  sel = 3'd0;
  logic [31:0] rd32;
  logic [3:0]  rd4;
  logic        seen32, seen4;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_mix_profiler #(.CNT_W(32), .DECODE_STATE(DEC)) dut32 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .state(state), .instr(instr),
    .pc(pc), .sel(sel), .rd_data(rd32), .illegal_seen(seen32));

  instr_mix_profiler #(.CNT_W(4), .DECODE_STATE(DEC)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .state(state), .instr(instr),
    .pc(pc), .sel(sel), .rd_data(rd4), .illegal_seen(seen4));

  // Model: class index 0..5 = BR LD ST IMM REG ILL, 6 = TOTAL.
  int unsigned m_cnt32 [7];
  int unsigned m_cnt4  [7];
  logic [31:0] m_pc;
  bit          m_seen;
  bit          m_prev_dec;
  logic [31:0] m_rd32;
  logic [3:0]  m_rd4;

  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit f7_zero, f7_alt;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    f7_zero = (f7 == 7'h00);
    f7_alt  = (f7 == 7'h20);
    if (op == 7'h63 && f3 == 3'd0) return 0;
    if (op == 7'h03 && f3 == 3'd2) return 1;
    if (op == 7'h23 && f3 == 3'd2) return 2;
    if (op == 7'h13) begin
      if (f3 == 3'd1) return f7_zero ? 3 : 5;
      if (f3 == 3'd5) return (f7_zero || f7_alt) ? 3 : 5;
      return 3;
    end
    if (op == 7'h33) begin
      if (f3 == 3'd0 || f3 == 3'd5) return (f7_zero || f7_alt) ? 4 : 5;
      return f7_zero ? 4 : 5;
    end
    return 5;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) begin m_cnt32[k] = 0; m_cnt4[k] = 0; end
      m_pc = 0; m_seen = 0; m_prev_dec = 1; m_rd32 = 0; m_rd4 = 0;
    end else begin
      bit ev;
      int c;
      logic [31:0] pcv;
      ev = (state == DEC) && !m_prev_dec && en;
      pcv = m_pc;
      if (sel == 3'd7) begin
        m_rd32 = pcv;
        m_rd4  = pcv[3:0];
      end else begin
        m_rd32 = m_cnt32[sel];
        m_rd4  = 4'(m_cnt4[sel]);
      end
      m_prev_dec = (state == DEC);
      if (clr) begin
        for (int k = 0; k < 7; k++) begin m_cnt32[k] = 0; m_cnt4[k] = 0; end
        m_pc = 0; m_seen = 0;
      end else if (ev) begin
        c = classify(instr);
        if (m_cnt32[c] < 32'hFFFF_FFFF) m_cnt32[c]++;
        if (m_cnt32[6] < 32'hFFFF_FFFF) m_cnt32[6]++;
        if (m_cnt4[c] < 15) m_cnt4[c]++;
        if (m_cnt4[6] < 15) m_cnt4[6]++;
        if (c == 5 && !m_seen) begin m_pc = pc; m_seen = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      n_vec += 4;
      if (rd32 !== m_rd32) begin
        n_err++; $display("FAIL model_rd32 t=%0t sel=%0d got %h exp %h", $time, sel, rd32, m_rd32);
      end
      if (rd4 !== m_rd4) begin
        n_err++; $display("FAIL model_rd4 t=%0t sel=%0d got %h exp %h", $time, sel, rd4, m_rd4);
      end
      if (seen32 !== m_seen) begin
        n_err++; $display("FAIL model_seen32 t=%0t got %b exp %b", $time, seen32, m_seen);
      end
      if (seen4 !== m_seen) begin
        n_err++; $display("FAIL model_seen4 t=%0t got %b exp %b", $time, seen4, m_seen);
      end
    end
  end

  task automatic entry(input logic [31:0] w, input logic [31:0] p, input int hold);
    @(negedge clk);
    state = DEC; instr = w; pc = p;
    repeat (hold) @(negedge clk);
    state = IDLE;
  endtask

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [2:0] s, input logic [31:0] e32,
                    input logic [3:0] e4);
    @(negedge clk);
    sel = s;
    @(negedge clk);
    lit({nm, "_32"}, rd32, e32);
    lit({nm, "_4"}, {28'h0, rd4}, {28'h0, e4});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    lit("reset_rd32", rd32, 32'h0);
    lit("reset_seen", {31'h0, seen32}, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    entry(ADDI, 32'h00, 1); entry(LW, 32'h04, 1); entry(SW, 32'h08, 1);
    entry(BEQ, 32'h0C, 1);  entry(ADD, 32'h10, 1); entry(SUB, 32'h14, 1);
    rd("t1_br", 3'd0, 1, 1);  rd("t1_ld", 3'd1, 1, 1);  rd("t1_st", 3'd2, 1, 1);
    rd("t1_imm", 3'd3, 1, 1); rd("t1_reg", 3'd4, 2, 2); rd("t1_ill", 3'd5, 0, 0);
    rd("t1_tot", 3'd6, 6, 6);

    entry(ADDI, 32'h18, 5);
    rd("t2_imm", 3'd3, 2, 2); rd("t2_tot", 3'd6, 7, 7);

    entry(BAD0, 32'h40, 1); entry(BAD1, 32'h44, 1);
    rd("t3_ill", 3'd5, 2, 2); rd("t3_pc", 3'd7, 32'h40, 4'h0);
    lit("t3_seen", {31'h0, seen32}, 32'h1);

    for (int i = 0; i < 17; i++) entry(ADD, 32'h100 + 4 * i, 1);
    rd("t4_reg", 3'd4, 19, 15); rd("t4_tot", 3'd6, 26, 15);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    rd("t4_clr_tot", 3'd6, 0, 0); rd("t4_clr_pc", 3'd7, 0, 0);
    lit("t4_clr_seen", {31'h0, seen4}, 32'h0);

    @(negedge clk); state = DEC; instr = ADD; clr = 1'b1;
    @(negedge clk); clr = 1'b0; state = IDLE;
    rd("t5_reg", 3'd4, 0, 0); rd("t5_tot", 3'd6, 0, 0);
    en = 1'b0;
    entry(ADD, 32'h200, 1); entry(ADDI, 32'h204, 2); entry(BAD0, 32'h208, 1);
    en = 1'b1;
    rd("t5_en_tot", 3'd6, 0, 0);
    lit("t5_en_seen", {31'h0, seen32}, 32'h0);

    entry(BAD0, 32'h80, 1);
    @(negedge clk); state = DEC; instr = ADDI; pc = 32'h84;
    @(negedge clk); sel = 3'd6;
    @(negedge clk);
    lit("t6_pre_tot", rd32, 32'd2);
    lit("t6_pre_seen", {31'h0, seen32}, 32'h1);
    #1 rst = 1'b1;
    #2;
    lit("t6_rst_rd32", rd32, 32'h0);
    lit("t6_rst_rd4", {28'h0, rd4}, 32'h0);
    lit("t6_rst_seen", {31'h0, seen32}, 32'h0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    state = IDLE;
    rd("t6_hold_tot", 3'd6, 0, 0);
    entry(ADD, 32'h90, 1);
    rd("t6_re_tot", 3'd6, 1, 1); rd("t6_re_reg", 3'd4, 1, 1);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
